// File: rtl/uart_arb_pkg.sv
// Shared types and default constants for the UART TX arbiter.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StWaitBusy,
    StWaitDone
  } arb_state_t;

  localparam int unsigned UART_ARB_N_REQ       = 4;
  localparam int unsigned UART_ARB_TIMEOUT_CYC = 1024;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester and UART TX core signals of the arbiter; slave is the arbiter side.
interface uart_tx_arbiter_if
  import uart_arb_pkg::*;
#(
  parameter int unsigned N_REQ  = UART_ARB_N_REQ,
  parameter int unsigned DATA_W = 8
);
  logic [N_REQ-1:0]             req_valid;
  logic [N_REQ-1:0][DATA_W-1:0] req_data;
  logic [N_REQ-1:0]             req_last;
  logic [N_REQ-1:0]             req_ready;
  logic [N_REQ-1:0]             grant;
  logic [DATA_W-1:0]            tx_data;
  logic                         tx_start;
  logic                         tx_busy;
  logic                         timeout_err;

  modport slave (
    input  req_valid, req_data, req_last, tx_busy,
    output req_ready, grant, tx_data, tx_start, timeout_err
  );

  modport master (
    output req_valid, req_data, req_last, tx_busy,
    input  req_ready, grant, tx_data, tx_start, timeout_err
  );
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first valid requester at or after ptr, wrapping.
module rr_pick #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic [N_REQ-1:0] req_valid,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] winner,
  output logic             any
);
  logic [PTR_W:0] pos;

  // Scan upward from ptr; explicit wrap keeps non-power-of-two N_REQ correct.
  always_comb begin
    winner = '0;
    any    = 1'b0;
    pos    = '0;
    for (int unsigned off = 0; off < N_REQ; off++) begin
      pos = {1'b0, ptr} + (PTR_W+1)'(off);
      if (pos >= (PTR_W+1)'(N_REQ)) pos = pos - (PTR_W+1)'(N_REQ);
      if (!any && req_valid[pos[PTR_W-1:0]]) begin
        winner[pos[PTR_W-1:0]] = 1'b1;
        any                    = 1'b1;
      end
    end
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX core between N_REQ byte-stream requesters.
// A grant is held for a whole message (until the byte flagged last has been sent).
// Optional idle-lock watchdog: define UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned N_REQ       = UART_ARB_N_REQ,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned TIMEOUT_CYC = UART_ARB_TIMEOUT_CYC
) (
  input logic              clk,
  input logic              rst_n,
  uart_tx_arbiter_if.slave bus
);
  localparam int unsigned PTR_W = $clog2(N_REQ);

  arb_state_t        state_q, state_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d, gid_q, gid_d, win_idx, gid_next;
  logic [N_REQ-1:0]  grant_q, grant_d, winner, req_ready;
  logic              any_valid, last_q, last_d, tx_start_q, tx_start_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
`endif

  rr_pick #(
    .N_REQ(N_REQ),
    .PTR_W(PTR_W)
  ) u_rr_pick (
    .req_valid(bus.req_valid),
    .ptr      (ptr_q),
    .winner   (winner),
    .any      (any_valid)
  );

  // One-hot winner to index, and the pointer value just past the owner.
  always_comb begin
    win_idx = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (winner[i]) win_idx = PTR_W'(i);
    end
    gid_next = (gid_q == PTR_W'(N_REQ - 1)) ? '0 : gid_q + PTR_W'(1);
  end

  // Next-state and handshake logic.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    gid_d      = gid_q;
    grant_d    = grant_q;
    last_d     = last_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    req_ready  = '0;
`ifdef UART_ARB_TIMEOUT_EN
    cnt_d      = cnt_q;
    timeout_d  = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (any_valid) begin
          gid_d   = win_idx;
          grant_d = winner;
          state_d = StLoad;
        end
      end
      StLoad: begin
        req_ready[gid_q] = bus.req_valid[gid_q] & ~bus.tx_busy;
        if (req_ready[gid_q]) begin
          tx_data_d  = bus.req_data[gid_q];
          last_d     = bus.req_last[gid_q];
          tx_start_d = 1'b1;
          state_d    = StWaitBusy;
`ifdef UART_ARB_TIMEOUT_EN
          cnt_d      = '0;
`endif
        end
`ifdef UART_ARB_TIMEOUT_EN
        else if (!bus.req_valid[gid_q]) begin
          // Owner went quiet mid-message: release the lock after TIMEOUT_CYC idle clocks.
          if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
            cnt_d     = '0;
            timeout_d = 1'b1;
            grant_d   = '0;
            ptr_d     = gid_next;
            state_d   = StIdle;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
`endif
      end
      StWaitBusy: begin
        if (bus.tx_busy) state_d = StWaitDone;
      end
      StWaitDone: begin
        if (!bus.tx_busy) begin
          if (last_q) begin
            ptr_d   = gid_next;
            grant_d = '0;
            state_d = StIdle;
          end else begin
            state_d = StLoad;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Arbiter state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      ptr_q      <= '0;
      gid_q      <= '0;
      grant_q    <= '0;
      last_q     <= 1'b0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      gid_q      <= gid_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  // Watchdog counter and its release pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.timeout_err = timeout_q;
`else
  logic unused_timeout_cyc;
  assign unused_timeout_cyc = ^TIMEOUT_CYC;
  assign bus.timeout_err    = 1'b0;
`endif

  assign bus.req_ready = req_ready;
  assign bus.grant     = grant_q;
  assign bus.tx_data   = tx_data_q;
  assign bus.tx_start  = tx_start_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: table vectors, directed corner cases and
// randomized message traffic checked against a message-level round-robin model.
module tb_uart_tx_arbiter;
  localparam int unsigned NR = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned TO = 50;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.N_REQ(NR), .DATA_W(DW)) bus ();

  uart_tx_arbiter #(
    .N_REQ      (NR),
    .DATA_W     (DW),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name, input int cyc);
    total++;
    bad++;
    $display("FAIL %s: no event within %0d cycles", name, cyc);
  endtask

  // UART TX core model: busy for 10 cycles starting the cycle after tx_start.
  int   busy_cnt;
  logic busy_force;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_cnt <= 0;
    else if (bus.tx_start) busy_cnt <= 10;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign bus.tx_busy = (busy_cnt != 0) | busy_force;

  // Frame monitor: records every tx_start with its owner and byte.
  typedef struct packed {
    logic [NR-1:0] g;
    logic [DW-1:0] d;
  } frame_t;
  frame_t frames[$];
  logic   prev_start = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_start = 1'b0;
    end else begin
      if (bus.tx_start) begin
        check("tx_start not back-to-back", prev_start, 0);
        check("grant one-hot at tx_start", $onehot(bus.grant), 1);
        frames.push_back('{g: bus.grant, d: bus.tx_data});
      end
      prev_start = bus.tx_start;
    end
  end

  // Per-requester byte queues {last, byte} consumed by the traffic driver.
  logic [8:0] rq[NR][$];
  bit         allow_drop = 0;
  int         mptr = 0;

  task automatic run_traffic(input int max_cyc);
    logic [NR-1:0] hs;
    int            hold[NR];
    bit            done;
    bit            empty;
    int            cyc;
    hs = '0;
    done = 0;
    cyc = 0;
    for (int i = 0; i < NR; i++) hold[i] = 0;
    frames.delete();
    while (!done) begin
      @(negedge clk);
      for (int i = 0; i < NR; i++) begin
        if (hs[i]) begin
          if (!rq[i][0][8] && allow_drop && $urandom_range(0, 2) == 0)
            hold[i] = $urandom_range(1, 5);
          void'(rq[i].pop_front());
        end else if (hold[i] > 0) begin
          hold[i]--;
        end
        bus.req_valid[i] = (rq[i].size() > 0) && (hold[i] == 0);
        bus.req_data[i]  = (rq[i].size() > 0) ? rq[i][0][7:0] : '0;
        bus.req_last[i]  = (rq[i].size() > 0) && rq[i][0][8];
      end
      #1;
      hs = bus.req_ready & bus.req_valid;
      if (bus.req_ready != '0)
        check("req_ready one-hot within grant",
              $onehot(bus.req_ready) && ((bus.req_ready & ~bus.grant) == '0), 1);
      empty = 1;
      for (int i = 0; i < NR; i++) if (rq[i].size() > 0) empty = 0;
      if (empty && bus.grant == '0 && !bus.tx_busy) done = 1;
      cyc++;
      if (!done && cyc >= max_cyc) begin
        timeout_fail("traffic completion", max_cyc);
        done = 1;
      end
    end
    bus.req_valid = '0;
    bus.req_last  = '0;
  endtask

  task automatic compare_frames(input string tag, input frame_t exp[$]);
    check($sformatf("%s frame count", tag), frames.size(), exp.size());
    for (int k = 0; k < exp.size() && k < frames.size(); k++) begin
      check($sformatf("%s frame %0d grant", tag, k), frames[k].g, exp[k].g);
      check($sformatf("%s frame %0d byte", tag, k), frames[k].d, exp[k].d);
    end
  endtask

  // Reference: whole messages served round-robin starting at mptr.
  task automatic build_expected(output frame_t exp[$]);
    logic [8:0] cp[NR][$];
    logic [8:0] b;
    frame_t     f;
    int         pick;
    exp.delete();
    for (int i = 0; i < NR; i++) cp[i] = rq[i];
    while (1) begin
      pick = -1;
      for (int o = 0; o < NR; o++) begin
        if (pick < 0 && cp[(mptr + o) % NR].size() > 0) pick = (mptr + o) % NR;
      end
      if (pick < 0) break;
      do begin
        b = cp[pick].pop_front();
        f.g = '0;
        f.g[pick] = 1'b1;
        f.d = b[7:0];
        exp.push_back(f);
      end while (!b[8]);
      mptr = (pick + 1) % NR;
    end
  endtask

  task automatic wait_busy(input logic lvl, input int max);
    int n = 0;
    while (bus.tx_busy !== lvl && n < max) begin
      @(negedge clk);
      n++;
    end
    if (bus.tx_busy !== lvl) timeout_fail($sformatf("tx_busy=%0b", lvl), max);
  endtask

  task automatic wait_start(input int max);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.tx_start && n < max);
    if (!bus.tx_start) timeout_fail("tx_start", max);
  endtask

  typedef struct {
    logic [NR-1:0] mask;
    int            n;
    int            order[NR];
  } vec_t;
  vec_t tbl[6];

  initial begin
    frame_t exp[$];
    frame_t f;
    bit     ok;
    int     j;

    // Single-byte messages from the masked requesters; order assumes ptr chaining from reset.
    tbl[0] = '{4'b0101, 2, '{0, 2, 0, 0}};
    tbl[1] = '{4'b1111, 4, '{3, 0, 1, 2}};
    tbl[2] = '{4'b0011, 2, '{0, 1, 0, 0}};
    tbl[3] = '{4'b1010, 2, '{3, 1, 0, 0}};
    tbl[4] = '{4'b1100, 2, '{2, 3, 0, 0}};
    tbl[5] = '{4'b1111, 4, '{0, 1, 2, 3}};

    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    busy_force    = 1'b0;

    #12;
    check("reset grant", bus.grant, 0);
    check("reset req_ready", bus.req_ready, 0);
    check("reset tx_start", bus.tx_start, 0);
    check("reset tx_data", bus.tx_data, 0);
    check("reset timeout_err", bus.timeout_err, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int e = 0; e < 6; e++) begin
      for (int i = 0; i < NR; i++)
        if (tbl[e].mask[i]) rq[i].push_back({1'b1, DW'(32'h30 + 16 * e + i)});
      run_traffic(400);
      exp.delete();
      for (int k = 0; k < tbl[e].n; k++) begin
        f.g = '0;
        f.g[tbl[e].order[k]] = 1'b1;
        f.d = DW'(32'h30 + 16 * e + tbl[e].order[k]);
        exp.push_back(f);
      end
      compare_frames($sformatf("vec%0d", e), exp);
    end

    // Single byte: grant at cycle 1, tx_start at cycle 2, release after busy falls.
    @(negedge clk);
    bus.req_valid[1] = 1'b1;
    bus.req_data[1]  = 8'h41;
    bus.req_last[1]  = 1'b1;
    @(negedge clk);
    #1;
    check("single grant cycle1", bus.grant, 4'b0010);
    check("single req_ready cycle1", bus.req_ready, 4'b0010);
    @(negedge clk);
    check("single tx_start cycle2", bus.tx_start, 1);
    check("single tx_data cycle2", bus.tx_data, 8'h41);
    bus.req_valid = '0;
    bus.req_last  = '0;
    wait_busy(1'b1, 20);
    wait_busy(1'b0, 20);
    @(negedge clk);
    check("single grant released", bus.grant, 0);

    // tx_busy already high on entering LOAD holds off req_ready.
    busy_force = 1'b1;
    bus.req_valid[3] = 1'b1;
    bus.req_data[3]  = 8'h20;
    bus.req_last[3]  = 1'b1;
    @(negedge clk);
    check("busy-load grant", bus.grant, 4'b1000);
    repeat (3) @(negedge clk);
    #1;
    check("busy-load req_ready held low", bus.req_ready, 0);
    busy_force = 1'b0;
    #1;
    check("busy-load req_ready after busy falls", bus.req_ready, 4'b1000);
    @(negedge clk);
    check("busy-load tx_start", bus.tx_start, 1);
    check("busy-load tx_data", bus.tx_data, 8'h20);
    bus.req_valid = '0;
    bus.req_last  = '0;
    wait_busy(1'b1, 20);
    wait_busy(1'b0, 20);
    repeat (2) @(negedge clk);

    // Packet lock: "ABC" from req0 while req1 waits.
    rq[0].push_back({1'b0, 8'h41});
    rq[0].push_back({1'b0, 8'h42});
    rq[0].push_back({1'b1, 8'h43});
    rq[1].push_back({1'b1, 8'h31});
    run_traffic(400);
    exp.delete();
    exp.push_back('{g: 4'b0001, d: 8'h41});
    exp.push_back('{g: 4'b0001, d: 8'h42});
    exp.push_back('{g: 4'b0001, d: 8'h43});
    exp.push_back('{g: 4'b0010, d: 8'h31});
    compare_frames("lock", exp);

    // Reset during WAIT_DONE of byte 2 of 3.
    @(negedge clk);
    bus.req_valid[2] = 1'b1;
    bus.req_data[2]  = 8'h61;
    bus.req_last[2]  = 1'b0;
    wait_start(10);
    check("reset-seq byte1", bus.tx_data, 8'h61);
    bus.req_data[2] = 8'h62;
    wait_start(40);
    check("reset-seq byte2", bus.tx_data, 8'h62);
    bus.req_data[2] = 8'h63;
    bus.req_last[2] = 1'b1;
    wait_busy(1'b1, 20);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midreset grant", bus.grant, 0);
    check("midreset req_ready", bus.req_ready, 0);
    check("midreset tx_start", bus.tx_start, 0);
    check("midreset tx_data", bus.tx_data, 0);
    check("midreset timeout_err", bus.timeout_err, 0);
    @(negedge clk);
    bus.req_valid = '0;
    bus.req_last  = '0;
    rst_n = 1'b1;
    mptr = 0;
    rq[3].push_back({1'b1, 8'h55});
    build_expected(exp);
    run_traffic(400);
    compare_frames("post-reset", exp);

    // Owner stalls mid-message.
    @(negedge clk);
    bus.req_valid[3] = 1'b1;
    bus.req_data[3]  = 8'h58;
    bus.req_last[3]  = 1'b0;
    @(negedge clk);
    check("stall grant", bus.grant, 4'b1000);
    wait_start(10);
    check("stall tx_data", bus.tx_data, 8'h58);
    bus.req_valid = '0;
    wait_busy(1'b1, 20);
    wait_busy(1'b0, 20);
`ifdef UART_ARB_TIMEOUT_EN
    j = 0;
    for (int c = 1; c <= 80 && j == 0; c++) begin
      @(negedge clk);
      if (bus.timeout_err) begin
        j = c;
        check("watchdog grant cleared", bus.grant, 0);
      end
    end
    if (j == 0) timeout_fail("timeout_err", 80);
    else check("watchdog pulse cycle", j, TO + 1);
    @(negedge clk);
    check("watchdog pulse one cycle", bus.timeout_err, 0);
    mptr = 0;
`else
    j = 0;
    ok = 1;
    repeat (200) begin
      @(negedge clk);
      if (bus.grant !== 4'b1000 || bus.timeout_err !== 1'b0) ok = 0;
    end
    check("lock held without watchdog", ok, 1);
    mptr = 3;
    rq[3].push_back({1'b1, 8'h59});
    build_expected(exp);
    run_traffic(100);
    compare_frames("stall release", exp);
`endif

    // Randomized traffic with mid-message valid drops.
    allow_drop = 1;
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < NR; i++) begin
        int nmsg = $urandom_range(0, 3);
        for (int m = 0; m < nmsg; m++) begin
          int len = $urandom_range(1, 4);
          for (int b = 0; b < len; b++)
            rq[i].push_back({b == len - 1, 8'($urandom)});
        end
      end
      build_expected(exp);
      run_traffic(4000);
      compare_frames($sformatf("rand%0d", r), exp);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares a single UART transmitter between `N_REQ` byte-stream requesters, for example a debug logger, a status reporter and a command-response path. It grants one requester at a time in round-robin order and keeps that grant until the requester's whole message has been sent. Each byte is handed to the transmitter with a one-cycle `tx_start` pulse. The block sits between the requesting logic and the UART TX core, and consumes that core's `tx_busy`.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters (2..8).
- `DATA_W`, 8: byte width.
- `TIMEOUT_CYC`, 1024: idle-lock watchdog limit in clocks; used only with `UART_ARB_TIMEOUT_EN`.

Ports:
- `clk`  in  1  system clock. One clock domain.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `req_valid`  in  N_REQ  requester i has a byte presented.
- `req_data`  in  N_REQ×DATA_W  byte from each requester (packed array).
- `req_last`  in  N_REQ  presented byte is the last byte of the message.
- `req_ready`  out  N_REQ  byte accepted this cycle. One-hot or zero.
- `grant`  out  N_REQ  one-hot lock owner. Zero when idle.
- `tx_data`  out  DATA_W  byte to the UART TX core. Registered.
- `tx_start`  out  1  one-cycle start pulse to the UART TX core.
- `tx_busy`  in  1  UART TX core is shifting a frame.
- `timeout_err`  out  1  one-cycle pulse when the watchdog releases a lock. Tied 0 when the watchdog is compiled out.

## Operation
FSM states are `IDLE`, `LOAD`, `WAIT_BUSY` and `WAIT_DONE`.

- **IDLE**
  - If any `req_valid` is high, pick the first valid requester at or after `ptr`, scanning upward and wrapping.
  - Register the winner as `gid` and `grant`, then go to `LOAD`.
- **LOAD**
  - `req_ready[gid] = req_valid[gid] & ~tx_busy`. This is combinational; all other `req_ready` bits are 0.
  - On handshake: `tx_data <= req_data[gid]`, `last_q <= req_last[gid]`, `tx_start <= 1`, go to `WAIT_BUSY`.
- **WAIT_BUSY**
  - `tx_start` returns to 0, so the pulse lasts exactly one cycle.
  - Stay until `tx_busy` is 1, then go to `WAIT_DONE`.
- **WAIT_DONE**
  - Stay until `tx_busy` is 0.
  - If `last_q` is 1: `ptr <= (gid+1) mod N_REQ`, `grant <= 0`, go to `IDLE`.
  - Otherwise go back to `LOAD`; the lock is held.

Boundary conditions:
- **Lock semantics:** while `grant` is nonzero, other requesters are ignored, even if the owner drops `req_valid` mid-message.
- **Single-byte message:** `req_last` high on the first byte releases the lock after that one frame.
- **`N_REQ` not a power of two:** `ptr` wraps explicitly from `N_REQ-1` to 0.
- **Request appears while in `WAIT_*`:** it waits for the next arbitration. No starvation: each requester is reached within `N_REQ` messages.
- **`tx_busy` high when entering `LOAD`:** `req_ready` stays low until `tx_busy` falls.
- **Reset mid-message:** all state clears immediately. The UART core owns any partial frame.

Reset values:
- Outputs: `grant=0`, `req_ready=0`, `tx_start=0`, `tx_data=0`, `timeout_err=0`.
- Internal: `ptr=0`, `gid=0`, `last_q=0`, state `IDLE`.

## Timing
- Cycle 0: request seen in `IDLE`.
- Cycle 1: `grant` valid. `req_ready` is high if `req_valid` is held.
- Cycle 2: `tx_start` high and `tx_data` valid.
- The TX core must raise `tx_busy` on the cycle after `tx_start` or later.
- Minimum gap between frames of one message: 1 cycle after `tx_busy` falls (return to `LOAD`), then `tx_start` on the following cycle.
- The next requester is granted 1 cycle after the last frame's `tx_busy` falls.

## Configuration
`UART_ARB_TIMEOUT_EN`
- **Defined:**
  - A counter runs while in `LOAD` with `req_valid[gid]` low and is cleared on any handshake.
  - When it reaches `TIMEOUT_CYC`: `timeout_err` pulses, `grant` clears, `ptr` advances past `gid`, and the FSM goes to `IDLE`.
- **Undefined:** no counter exists. A lock is held until `req_last` is accepted, and `timeout_err` is tied to 0.

## Structure
- Shared package `uart_arb_pkg`:
  - FSM state enum `arb_state_t`.
  - Default constants `UART_ARB_N_REQ` and `UART_ARB_TIMEOUT_CYC`.
- One sub-module, `rr_pick`: a combinational round-robin selector.
  - Inputs: `req_valid` and `ptr`.
  - Outputs: one-hot winner and `any` flag.
  - Instantiated once.

## Test plan
Use a UART TX model with `tx_busy` high 10 cycles after `tx_start`, `N_REQ=4`, and `TIMEOUT_CYC=50`.
- **Single byte:** req1 sends 0x41 with `last` → `grant=0010` at cycle 1, `tx_start` at cycle 2 with `tx_data=0x41`, then `grant=0` and `ptr=2` after `tx_busy` falls.
- **Simultaneous requests:** req0 and req2 each send 1 byte with `ptr=0` → 0x30 from req0 first, then req2's 0x32. `tx_start` is never asserted for two cycles in a row.
- **Packet lock:** req0 sends "ABC" (`last` on 'C') while req1 holds valid → frames go A, B, C, then req1. `req_ready[1]` stays 0 until the grant moves to req1.
- **Fairness:** all four requesters continuously send 1-byte messages → grant order is 0,1,2,3,0, and each `tx_start` carries the matching requester's byte.
- **Watchdog (with `UART_ARB_TIMEOUT_EN`):** req3 sends 'X' without `last`, then drops valid → `timeout_err` pulses 50 cycles into `LOAD`, `grant` clears and `ptr=0`. Without the macro, the grant stays `1000` indefinitely.
- **Reset mid-message:** assert `rst_n=0` during `WAIT_DONE` of byte 2 of 3 → all outputs read their reset values asynchronously, and a fresh request is accepted normally after release.
